board_winner_scan: RTL and testbench

Sequential, parametrised successor to the three-cell line comparator. It scans a full N×N board one line per cycle and reports the first winning line, the winning player and a draw flag. It sits between the board register file and the game-control FSM. Control issues `start` after every move and consumes the registered result on `done`.

---
 rtl/board_winner_scan.sv | 192 +++++++++++++++++++
 tb/tb_board_winner_scan.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_winner_scan.sv
`default_nettype none
// ============================================================================
//  Module   : board_winner_scan
//  Purpose  : Scans an N x N game board one line per cycle (rows, columns,
//             main diagonal, anti-diagonal) and reports the first winning
//             line, the winning player code and a draw flag.
//  Ports    : clk       - system clock, rising edge
//             rst_n     - asynchronous active-low reset
//             start     - scan request, honoured only while idle
//             board     - 2 bits per cell, cell (r,c) at [2*(r*N+c) +: 2]
//             busy      - high while scanning
//             done      - one-cycle pulse, results valid from this cycle
//             winner    - a winning line was found
//             who       - winning cell code (01/10), 00 if none
//             win_line  - index of the winning line, 0 if none
//             draw      - no winner and no empty cell
//  Options  : BOARD_DRAW_DETECT_EN - when defined, draw detection is built;
//             otherwise draw is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module board_winner_scan #(
   parameter int N  = 3,
   parameter int LW = $clog2(2*N+2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2*N*N-1:0]  board,
   output logic              busy,
   output logic              done,
   output logic              winner,
   output logic [1:0]        who,
   output logic [LW-1:0]     win_line,
   output logic              draw
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [LW-1:0] c_last_idx = LW'(2*N+1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2*N*N-1:0]     r_snap;
   logic [LW-1:0]        r_idx;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_winner;
   logic [1:0]           r_who;
   logic [LW-1:0]        r_win_line;
   logic                 r_draw;

   logic [1:0]           w_cell0;
   logic                 w_all_eq;
   logic                 w_win;
   logic                 w_last;
   logic                 w_finish;
   logic                 w_full;

   // Gather the N cells of line r_idx from the snapshot and test that they
   // are all equal to the first one.
   always_comb begin
      int         li;
      int         r;
      int         c;
      logic [1:0] cur;
      li       = int'(r_idx);
      r        = 0;
      c        = 0;
      cur      = 2'b00;
      w_cell0  = 2'b00;
      w_all_eq = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (li < N) begin
            r = li;
            c = i;
         end else if (li < 2*N) begin
            r = i;
            c = li - N;
         end else if (li == 2*N) begin
            r = i;
            c = i;
         end else begin
            r = i;
            c = N - 1 - i;
         end
         cur = r_snap[2*(r*N+c) +: 2];
         if (i == 0) begin
            w_cell0 = cur;
         end else if (cur != w_cell0) begin
            w_all_eq = 1'b0;
         end
      end
   end

   // Code 11 (invalid) and 00 (empty) never win even when a line is uniform.
   assign w_win    = w_all_eq && ((w_cell0 == 2'b01) || (w_cell0 == 2'b10));
   assign w_last   = (r_idx == c_last_idx);
   assign w_finish = w_win || w_last;

`ifdef BOARD_DRAW_DETECT_EN
   always_comb begin
      w_full = 1'b1;
      for (int i = 0; i < N*N; i++) begin
         if (r_snap[2*i +: 2] == 2'b00) begin
            w_full = 1'b0;
         end
      end
   end
`else
   assign w_full = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SCAN;
         S_SCAN:  if (w_finish) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap     <= '0;
         r_idx      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_winner   <= 1'b0;
         r_who      <= 2'b00;
         r_win_line <= '0;
         r_draw     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_snap     <= board;
                  r_idx      <= '0;
                  r_busy     <= 1'b1;
                  r_winner   <= 1'b0;
                  r_who      <= 2'b00;
                  r_win_line <= '0;
                  r_draw     <= 1'b0;
               end
            end
            S_SCAN: begin
               if (w_win) begin
                  r_winner   <= 1'b1;
                  r_who      <= w_cell0;
                  r_win_line <= r_idx;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
               end else if (w_last) begin
                  // Only reached with no winner, so draw is just "board full".
                  r_draw     <= w_full;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
               end else begin
                  r_idx      <= r_idx + LW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign winner   = r_winner;
   assign who      = r_who;
   assign win_line = r_win_line;
   assign draw     = r_draw;

endmodule
`default_nettype wire

// File: tb/tb_board_winner_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_winner_scan
//  Purpose  : Self-checking bench for board_winner_scan at N=3 and N=4.
//             A line-based reference model predicts every output each cycle;
//             directed boards pin the model with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_winner_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start3 = 1'b0;
   logic        start4 = 1'b0;
   logic [17:0] board3 = '0;
   logic [31:0] board4 = '0;

   logic        busy3, done3, winner3, draw3;
   logic [1:0]  who3;
   logic [2:0]  line3;
   logic        busy4, done4, winner4, draw4;
   logic [1:0]  who4;
   logic [3:0]  line4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   board_winner_scan #(.N(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .board(board3),
      .busy(busy3), .done(done3), .winner(winner3), .who(who3),
      .win_line(line3), .draw(draw3)
   );

   board_winner_scan #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .board(board4),
      .busy(busy4), .done(done4), .winner(winner4), .who(who4),
      .win_line(line4), .draw(draw4)
   );

`ifdef BOARD_DRAW_DETECT_EN
   localparam int c_draw_en = 1;
`else
   localparam int c_draw_en = 0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Cell index of the i-th cell of line l on an n x n board.
   function automatic int cell_of(input int n, input int l, input int i);
      if (l < n)        return l*n + i;
      else if (l < 2*n) return i*n + (l - n);
      else if (l == 2*n) return i*n + i;
      else              return i*n + (n - 1 - i);
   endfunction

   function automatic void evaluate(input logic [127:0] b, input int n,
                                    output logic w, output logic [1:0] code,
                                    output int line, output logic dr);
      logic [1:0] v0;
      logic       ok;
      w = 1'b0; code = 2'b00; line = 0; dr = 1'b1;
      for (int c = 0; c < n*n; c++)
         if (b[2*c +: 2] == 2'b00) dr = 1'b0;
      for (int l = 0; l < 2*n+2; l++) begin
         if (!w) begin
            v0 = b[2*cell_of(n, l, 0) +: 2];
            ok = (v0 == 2'b01) || (v0 == 2'b10);
            for (int i = 1; i < n; i++)
               if (b[2*cell_of(n, l, i) +: 2] != v0) ok = 1'b0;
            if (ok) begin
               w = 1'b1; code = v0; line = l;
            end
         end
      end
      if (w || c_draw_en == 0) dr = 1'b0;
   endfunction

   logic       m_busy[2], m_done[2], m_win[2], m_draw[2], m_indone[2];
   logic       p_win[2], p_draw[2];
   logic [1:0] m_who[2], p_who[2];
   int         m_line[2], p_line[2], m_cnt[2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_done[k] = 0; m_win[k] = 0; m_draw[k] = 0;
         m_indone[k] = 0; m_who[k] = 0; m_line[k] = 0; m_cnt[k] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               m_busy[k] = 0; m_done[k] = 0; m_win[k] = 0; m_draw[k] = 0;
               m_indone[k] = 0; m_who[k] = 0; m_line[k] = 0; m_cnt[k] = 0;
            end else if (m_indone[k]) begin
               m_indone[k] = 0;
               m_done[k]   = 0;
            end else if (m_cnt[k] > 0) begin
               m_cnt[k]--;
               if (m_cnt[k] == 0) begin
                  m_busy[k] = 0; m_done[k] = 1; m_indone[k] = 1;
                  m_win[k] = p_win[k]; m_who[k] = p_who[k];
                  m_line[k] = p_line[k]; m_draw[k] = p_draw[k];
               end
            end else if ((k == 0) ? start3 : start4) begin
               if (k == 0) evaluate({110'b0, board3}, 3, p_win[k], p_who[k], p_line[k], p_draw[k]);
               else        evaluate({96'b0,  board4}, 4, p_win[k], p_who[k], p_line[k], p_draw[k]);
               m_cnt[k]  = p_win[k] ? p_line[k] + 1 : 2*(k + 3) + 2;
               m_busy[k] = 1; m_win[k] = 0; m_who[k] = 0; m_line[k] = 0; m_draw[k] = 0;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("busy3",   busy3,   m_busy[0]);
         chk("done3",   done3,   m_done[0]);
         chk("winner3", winner3, m_win[0]);
         chk("who3",    who3,    m_who[0]);
         chk("line3",   line3,   m_line[0]);
         chk("draw3",   draw3,   m_draw[0]);
         chk("busy4",   busy4,   m_busy[1]);
         chk("done4",   done4,   m_done[1]);
         chk("winner4", winner4, m_win[1]);
         chk("who4",    who4,    m_who[1]);
         chk("line4",   line4,   m_line[1]);
         chk("draw4",   draw4,   m_draw[1]);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [17:0] b3(input logic [1:0] c0, c1, c2, c3, c4,
                                      c5, c6, c7, c8);
      return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
   endfunction

   function automatic logic [127:0] rboard(input int n);
      logic [127:0] b;
      int           r, l;
      logic [1:0]   code;
      b = '0;
      for (int c = 0; c < n*n; c++) begin
         r = $urandom_range(0, 9);
         b[2*c +: 2] = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 1) == 1) begin
         l    = $urandom_range(0, 2*n+1);
         code = 2'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) b[2*cell_of(n, l, i) +: 2] = code;
      end
      return b;
   endfunction

   // Directed scan with literal expectations on busy length and results.
   task automatic run(input int k, input logic [31:0] b, input bit disturb,
                      input string nm, input int e_line, input int e_who,
                      input int e_win, input int e_draw, input int e_busy);
      int nb = 0;
      int t  = 0;
      @(negedge clk);
      if (k == 0) begin board3 = b[17:0]; start3 = 1'b1; end
      else        begin board4 = b;       start4 = 1'b1; end
      @(negedge clk);
      start3 = 1'b0; start4 = 1'b0;
      while (!((k == 0) ? done3 : done4) && t < 40) begin
         if ((k == 0) ? busy3 : busy4) nb++;
         if (disturb && t == 1) begin
            board3 = ~board3; start3 = 1'b1;
         end else begin
            start3 = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      start3 = 1'b0;
      chk({nm, "_done"},   (k == 0) ? done3 : done4, 1);
      chk({nm, "_busy"},   nb, e_busy);
      chk({nm, "_line"},   (k == 0) ? 32'(line3) : 32'(line4), e_line);
      chk({nm, "_who"},    (k == 0) ? who3 : who4, e_who);
      chk({nm, "_winner"}, (k == 0) ? winner3 : winner4, e_win);
      chk({nm, "_draw"},   (k == 0) ? draw3 : draw4, e_draw);
   endtask

   logic [127:0] rb;
   bit           saw_done;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy3, 0);
      chk("rst_done", done3, 0);
      chk("rst_win",  winner3, 0);
      chk("rst_who",  who3, 0);
      chk("rst_line", line3, 0);
      chk("rst_draw", draw3, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Row 0 of player 1
      run(0, 32'(b3(1, 1, 1, 0, 0, 0, 0, 0, 0)), 0, "row0", 0, 1, 1, 0, 1);
      // Anti-diagonal of player 2, no other line
      run(0, 32'(b3(1, 1, 2, 0, 2, 1, 2, 1, 0)), 0, "anti", 7, 2, 1, 0, 8);
      // Full board without a line
      run(0, 32'(b3(1, 2, 1, 1, 2, 2, 2, 1, 1)), 0, "full", 0, 0, 0, c_draw_en, 8);
      // Uniform invalid row 0 ignored, row 2 wins; board/start disturbed mid-scan
      run(0, 32'(b3(3, 3, 3, 0, 0, 0, 1, 1, 1)), 1, "inval", 2, 1, 1, 0, 3);
      // N=4: row 3 and column 0 both player 2, lowest index wins
      run(1, {8'hAA, 8'h02, 8'h02, 8'h02}, 0, "n4", 3, 2, 1, 0, 4);
      // Back-to-back: next start in the idle cycle right after done
      run(0, 32'(b3(0, 0, 0, 0, 0, 0, 2, 2, 2)), 0, "b2b", 2, 2, 1, 0, 3);

      // Asynchronous reset in scan cycle 3
      @(negedge clk);
      board3 = b3(1, 1, 2, 0, 2, 1, 2, 1, 0); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy3, 0);
      chk("arst_done", done3, 0);
      chk("arst_line", line3, 0);
      saw_done = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done3) saw_done = 1;
      end
      chk("arst_nodone", saw_done, 0);
      run(0, 32'(b3(1, 1, 1, 0, 0, 0, 0, 0, 0)), 0, "after_rst", 0, 1, 1, 0, 1);

      // Random boards, starts and board changes on both instances
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            rb = rboard(3); board3 = rb[17:0];
         end
         if ($urandom_range(0, 3) == 0) begin
            rb = rboard(4); board4 = rb[31:0];
         end
         start3 = ($urandom_range(0, 2) == 0);
         start4 = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      start3 = 1'b0; start4 = 1'b0;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
